// File: rtl/vedic_mul32_seq.sv
// rtl/vedic_mul32_seq.sv - multi-cycle 32x32 multiplier sequencing four half-products through one vedic_16bit core
// Optional build macro: VEDIC_SEQ_SIGNED_EN (two's complement operands via sign-magnitude)

module vedic_core #(
    parameter int W = 16
) (
    input  logic [W-1:0]   x,
    input  logic [W-1:0]   y,
    output logic [2*W-1:0] z
);
    generate
        if (W == 2) begin : g_base
            // Urdhva-tiryagbhyam on 2 bits: vertical, crosswise, vertical
            logic c1;
            assign c1   = (x[1] & y[0]) & (x[0] & y[1]);
            assign z[0] = x[0] & y[0];
            assign z[1] = (x[1] & y[0]) ^ (x[0] & y[1]);
            assign z[2] = (x[1] & y[1]) ^ c1;
            assign z[3] = (x[1] & y[1]) & c1;
        end else begin : g_rec
            localparam int H = W / 2;
            logic [W-1:0] ll;
            logic [W-1:0] lh;
            logic [W-1:0] hl;
            logic [W-1:0] hh;

            vedic_core #(.W(H)) u_ll (.x(x[H-1:0]), .y(y[H-1:0]), .z(ll));
            vedic_core #(.W(H)) u_lh (.x(x[H-1:0]), .y(y[W-1:H]), .z(lh));
            vedic_core #(.W(H)) u_hl (.x(x[W-1:H]), .y(y[H-1:0]), .z(hl));
            vedic_core #(.W(H)) u_hh (.x(x[W-1:H]), .y(y[W-1:H]), .z(hh));

            assign z = {hh, ll}
                     + {{H{1'b0}}, lh, {H{1'b0}}}
                     + {{H{1'b0}}, hl, {H{1'b0}}};
        end
    endgenerate
endmodule

module vedic_16bit (
    input  logic [15:0] x,
    input  logic [15:0] y,
    output logic [31:0] z
);
    vedic_core #(.W(16)) u_core (.x(x), .y(y), .z(z));
endmodule

module vedic_mul32_seq #(
    parameter int ACC_W = 64,
    parameter int STEPS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      a,
    input  logic [31:0]      b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] p,
    output logic             busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] LAST_STEP = 2'(STEPS - 1);

    state_t           state;
    logic [1:0]       step;
    logic [31:0]      a_r;
    logic [31:0]      b_r;
    logic [ACC_W-1:0] acc;
    logic [15:0]      core_x;
    logic [15:0]      core_y;
    logic [31:0]      core_z;
    logic [ACC_W-1:0] term;
    logic [ACC_W-1:0] sum;
    logic [ACC_W-1:0] result;
    logic [31:0]      a_mag;
    logic [31:0]      b_mag;

`ifdef VEDIC_SEQ_SIGNED_EN
    logic sign_r;
    // -(-2^31) wraps back to 0x8000_0000, which is the correct unsigned magnitude
    assign a_mag  = a[31] ? (~a + 32'd1) : a;
    assign b_mag  = b[31] ? (~b + 32'd1) : b;
    assign result = sign_r ? (~sum + {{(ACC_W-1){1'b0}}, 1'b1}) : sum;
`else
    assign a_mag  = a;
    assign b_mag  = b;
    assign result = sum;
`endif

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_comb begin
        core_x = a_r[15:0];
        core_y = b_r[15:0];
        term   = {{(ACC_W-32){1'b0}}, core_z};
        case (step)
            2'd0: begin
                core_x = a_r[15:0];
                core_y = b_r[15:0];
                term   = {{(ACC_W-32){1'b0}}, core_z};
            end
            2'd1: begin
                core_x = a_r[15:0];
                core_y = b_r[31:16];
                term   = {{(ACC_W-48){1'b0}}, core_z, 16'd0};
            end
            2'd2: begin
                core_x = a_r[31:16];
                core_y = b_r[15:0];
                term   = {{(ACC_W-48){1'b0}}, core_z, 16'd0};
            end
            default: begin
                core_x = a_r[31:16];
                core_y = b_r[31:16];
                term   = {core_z, 32'd0};
            end
        endcase
    end

    vedic_16bit u_core (.x(core_x), .y(core_y), .z(core_z));

    assign sum = acc + term;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            step      <= 2'd0;
            a_r       <= 32'd0;
            b_r       <= 32'd0;
            acc       <= '0;
            p         <= '0;
            out_valid <= 1'b0;
`ifdef VEDIC_SEQ_SIGNED_EN
            sign_r    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= a_mag;
                        b_r   <= b_mag;
`ifdef VEDIC_SEQ_SIGNED_EN
                        sign_r <= a[31] ^ b[31];
`endif
                        acc   <= '0;
                        step  <= 2'd0;
                        state <= MUL;
                    end
                end
                MUL: begin
                    acc  <= sum;
                    step <= step + 2'd1;
                    if (step == LAST_STEP) begin
                        p         <= result;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vedic_mul32_seq.sv
// tb/tb_vedic_mul32_seq.sv - directed self-checking bench for vedic_mul32_seq

module tb_vedic_mul32_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] p;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vedic_mul32_seq #(.ACC_W(64), .STEPS(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .p(p), .busy(busy)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    // Accept one request, measure latency, hold backpressure, then hand off.
    task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic [63:0] exp_p, input int hold);
        int edges;
        @(negedge clk);
        check_eq({tag, ":in_ready_idle"}, 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        a         = av;
        b         = bv;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = 32'hDEAD_BEEF;
        b        = 32'hCAFE_F00D;
        edges    = 0;
        @(negedge clk);
        check_eq({tag, ":in_ready_mul"}, 64'(in_ready), 64'd0);
        while (!out_valid && edges < 20) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check_eq({tag, ":latency"}, 64'(edges), 64'd4);
        check_eq({tag, ":p"}, p, exp_p);
        check_eq({tag, ":in_ready_done"}, 64'(in_ready), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq({tag, ":held_valid"}, 64'(out_valid), 64'd1);
            check_eq({tag, ":held_p"}, p, exp_p);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check_eq({tag, ":valid_after"}, 64'(out_valid), 64'd0);
        check_eq({tag, ":idle_after"}, 64'(in_ready), 64'd1);
        check_eq({tag, ":p_kept"}, p, exp_p);
    endtask

    initial begin
        int cyc;
        int nacc;
        int nout;
        int acc_cyc [2];
        logic [63:0] bb_exp [2];
        logic took;
        logic rose;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 32'd0;
        b         = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_eq("rst:in_ready", 64'(in_ready), 64'd1);
        check_eq("rst:out_valid", 64'(out_valid), 64'd0);
        check_eq("rst:busy", 64'(busy), 64'd0);
        check_eq("rst:p", p, 64'd0);

        run_op("basic", 32'h0001_0003, 32'h0002_0005, 64'h0000_0002_000B_000F, 0);
        run_op("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 6);
        run_op("step1", 32'h0000_FFFF, 32'hFFFF_0000, 64'h0000_FFFE_0001_0000, 0);
        run_op("step2", 32'h0002_0000, 32'h0000_0003, 64'h0000_0000_0006_0000, 0);
        run_op("step3", 32'h1234_0000, 32'h0001_0000, 64'h0000_1234_0000_0000, 0);

        // Back-to-back with out_ready tied high and in_valid held
        bb_exp[0] = 64'd21;
        bb_exp[1] = 64'h0000_0001_0000_0000;
        acc_cyc[0] = 0;
        acc_cyc[1] = 0;
        cyc  = 0;
        nacc = 0;
        nout = 0;
        @(negedge clk);
        in_valid  = 1'b1;
        a         = 32'd3;
        b         = 32'd7;
        out_ready = 1'b1;
        while (nout < 2 && cyc < 40) begin
            took = in_ready && in_valid;
            if (took && nacc < 2) begin
                acc_cyc[nacc] = cyc;
                nacc++;
            end
            if (out_valid) begin
                check_eq("b2b:p", p, bb_exp[nout]);
                nout++;
            end
            @(posedge clk);
            #1;
            if (took && nacc == 1) begin
                a = 32'h0001_0000;
                b = 32'h0001_0000;
            end else if (took && nacc == 2) begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_eq("b2b:outputs", 64'(nout), 64'd2);
        check_eq("b2b:spacing_ge5", 64'((acc_cyc[1] - acc_cyc[0]) >= 5), 64'd1);

        // Reset while at step 2
        @(negedge clk);
        in_valid = 1'b1;
        a        = 32'hFFFF_FFFF;
        b        = 32'h1234_5678;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_eq("midrst:in_ready", 64'(in_ready), 64'd1);
        check_eq("midrst:busy", 64'(busy), 64'd0);
        check_eq("midrst:acc", dut.acc, 64'd0);
        rose = out_valid;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rose = rose | out_valid;
        end
        check_eq("midrst:no_valid", 64'(rose), 64'd0);

        run_op("after_rst", 32'd6, 32'd9, 64'd54, 1);

`ifdef VEDIC_SEQ_SIGNED_EN
        run_op("sgn_neg", 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 0);
        run_op("sgn_min", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
